// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and types for the store packer
package mem_pkg;

  localparam int NUM_LANES  = 8;
  localparam int WORD_W     = 32;
  localparam int LINE_BYTES = 32;
  localparam int TAG_W      = 27;
  localparam int OFF_W      = 3;

  typedef logic [NUM_LANES-1:0] lane_mask_t;
  typedef logic [TAG_W-1:0]     line_tag_t;
  typedef logic [OFF_W-1:0]     word_off_t;

endpackage

// File: rtl/mem_line_group.sv
// rtl/mem_line_group.sv - selects the next cache line from the pending lanes and packs its words
module mem_line_group
  import mem_pkg::*;
(
  input  lane_mask_t                    pend,
  input  logic [NUM_LANES*WORD_W-1:0]   st_addr,
  input  logic [NUM_LANES*WORD_W-1:0]   st_data,
  output line_tag_t                     leader_tag,
  output lane_mask_t                    group,
  output logic [NUM_LANES*WORD_W-1:0]   line_data,
  output logic [NUM_LANES-1:0]          word_en,
  output logic [3:0]                    conflicts
);

  line_tag_t              tags [NUM_LANES];
  word_off_t              offs [NUM_LANES];
  logic [2*NUM_LANES-1:0] addr_lsbs;
  logic                   unused_addr_lsbs;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_dec
    assign tags[i]             = st_addr[i*WORD_W+5 +: TAG_W];
    assign offs[i]             = st_addr[i*WORD_W+2 +: OFF_W];
    assign addr_lsbs[2*i +: 2] = st_addr[i*WORD_W +: 2];
  end

  // Byte offset within the word is meaningless for word-aligned stores.
  assign unused_addr_lsbs = ^addr_lsbs;

  always_comb begin
    leader_tag = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (pend[i]) leader_tag = tags[i];
    end
  end

  // Ascending lane order lets the highest lane overwrite a shared word.
  always_comb begin
    group     = '0;
    line_data = '0;
    word_en   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      group[i] = pend[i] && (tags[i] == leader_tag);
      if (group[i]) begin
        line_data[offs[i]*WORD_W +: WORD_W] = st_data[i*WORD_W +: WORD_W];
        word_en[offs[i]]                    = 1'b1;
      end
    end
    conflicts = 4'($countones(group) - $countones(word_en));
  end

endmodule

// File: rtl/mem_store_packer.sv
// rtl/mem_store_packer.sv - packs a warp store into per-line cache writes, then releases the scoreboard
// Optional saturating statistics counters under MEM_ST_PACK_STATS_EN.
module mem_store_packer #(
  parameter int NUM_LANES = 8,
  parameter int WORD_W    = 32
) (
  input  logic                        clk,
  input  logic                        resetb,
  input  logic                        st_valid,
  output logic                        st_ready,
  input  logic [2:0]                  warp_ID,
  input  logic [1:0]                  scb_ID,
  input  logic [NUM_LANES-1:0]        thread_mask,
  input  logic [NUM_LANES*WORD_W-1:0] st_addr,
  input  logic [NUM_LANES*WORD_W-1:0] st_data,
  output logic                        wr_valid_o,
  input  logic                        wr_ready,
  output logic [26:0]                 wr_line_addr_o,
  output logic [NUM_LANES*WORD_W-1:0] wr_data_o,
  output logic [NUM_LANES-1:0]        wr_word_en_o,
  output logic                        pos_feedback_valid_o,
  output logic [2:0]                  pos_feedback_warpID_o,
  output logic [1:0]                  pos_feedback_scbID_o,
  output logic [NUM_LANES-1:0]        pos_feedback_mask_o
`ifdef MEM_ST_PACK_STATS_EN
  ,
  output logic [15:0]                 stat_lines_o,
  output logic [15:0]                 stat_conflicts_o
`endif
);
  import mem_pkg::*;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PACK = 2'd1;
  localparam logic [1:0] S_FB   = 2'd2;

  logic [1:0]                  state;
  logic [2:0]                  warp_q;
  logic [1:0]                  scb_q;
  lane_mask_t                  mask_q;
  lane_mask_t                  pend;
  lane_mask_t                  group_q;
  logic [NUM_LANES*WORD_W-1:0] addr_q;
  logic [NUM_LANES*WORD_W-1:0] data_q;

  lane_mask_t                  pend_next;
  lane_mask_t                  grp_pend;
  logic [NUM_LANES*WORD_W-1:0] grp_addr_src;
  logic [NUM_LANES*WORD_W-1:0] grp_data_src;
  line_tag_t                   grp_tag;
  lane_mask_t                  grp_mask;
  logic [NUM_LANES*WORD_W-1:0] grp_data;
  logic [NUM_LANES-1:0]        grp_en;
  logic [3:0]                  grp_conf;

  assign st_ready  = (state == S_IDLE);
  assign pend_next = pend & ~group_q;

  // The grouper looks at the incoming request while idle so the first write
  // is registered on the accept edge; afterwards it looks one group ahead.
  always_comb begin
    grp_pend     = pend_next;
    grp_addr_src = addr_q;
    grp_data_src = data_q;
    if (state == S_IDLE) begin
      grp_pend     = thread_mask;
      grp_addr_src = st_addr;
      grp_data_src = st_data;
    end
  end

  mem_line_group u_group (
    .pend       (grp_pend),
    .st_addr    (grp_addr_src),
    .st_data    (grp_data_src),
    .leader_tag (grp_tag),
    .group      (grp_mask),
    .line_data  (grp_data),
    .word_en    (grp_en),
    .conflicts  (grp_conf)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state                 <= S_IDLE;
      warp_q                <= '0;
      scb_q                 <= '0;
      mask_q                <= '0;
      pend                  <= '0;
      group_q               <= '0;
      addr_q                <= '0;
      data_q                <= '0;
      wr_valid_o            <= 1'b0;
      wr_line_addr_o        <= '0;
      wr_data_o             <= '0;
      wr_word_en_o          <= '0;
      pos_feedback_valid_o  <= 1'b0;
      pos_feedback_warpID_o <= '0;
      pos_feedback_scbID_o  <= '0;
      pos_feedback_mask_o   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (st_valid) begin
            warp_q <= warp_ID;
            scb_q  <= scb_ID;
            mask_q <= thread_mask;
            addr_q <= st_addr;
            data_q <= st_data;
            pend   <= thread_mask;
            if (thread_mask != '0) begin
              state          <= S_PACK;
              wr_valid_o     <= 1'b1;
              wr_line_addr_o <= grp_tag;
              wr_data_o      <= grp_data;
              wr_word_en_o   <= grp_en;
              group_q        <= grp_mask;
            end else begin
              state                 <= S_FB;
              pos_feedback_valid_o  <= 1'b1;
              pos_feedback_warpID_o <= warp_ID;
              pos_feedback_scbID_o  <= scb_ID;
              pos_feedback_mask_o   <= thread_mask;
            end
          end
        end
        S_PACK: begin
          if (wr_ready) begin
            pend <= pend_next;
            if (pend_next == '0) begin
              state                 <= S_FB;
              wr_valid_o            <= 1'b0;
              wr_line_addr_o        <= '0;
              wr_data_o             <= '0;
              wr_word_en_o          <= '0;
              group_q               <= '0;
              pos_feedback_valid_o  <= 1'b1;
              pos_feedback_warpID_o <= warp_q;
              pos_feedback_scbID_o  <= scb_q;
              pos_feedback_mask_o   <= mask_q;
            end else begin
              wr_line_addr_o <= grp_tag;
              wr_data_o      <= grp_data;
              wr_word_en_o   <= grp_en;
              group_q        <= grp_mask;
            end
          end
        end
        S_FB: begin
          state                 <= S_IDLE;
          pos_feedback_valid_o  <= 1'b0;
          pos_feedback_warpID_o <= '0;
          pos_feedback_scbID_o  <= '0;
          pos_feedback_mask_o   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_ST_PACK_STATS_EN
  logic [3:0]  conf_q;
  logic        load_group;
  logic [16:0] conf_sum;

  assign load_group = ((state == S_IDLE) && st_valid && (thread_mask != '0)) ||
                      ((state == S_PACK) && wr_ready && (pend_next != '0));
  assign conf_sum   = {1'b0, stat_conflicts_o} + {13'd0, conf_q};

  // Conflicts are credited only when the write carrying them is accepted.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      conf_q           <= '0;
      stat_lines_o     <= '0;
      stat_conflicts_o <= '0;
    end else begin
      if (load_group) conf_q <= grp_conf;
      if (wr_valid_o && wr_ready) begin
        if (stat_lines_o != 16'hFFFF) stat_lines_o <= stat_lines_o + 16'd1;
        stat_conflicts_o <= conf_sum[16] ? 16'hFFFF : conf_sum[15:0];
      end
    end
  end
`else
  logic unused_conf;
  assign unused_conf = ^grp_conf;
`endif

endmodule

// File: tb/tb_mem_store_packer.sv
// tb/tb_mem_store_packer.sv - scoreboard bench for mem_store_packer with a line-grouping reference model
module tb_mem_store_packer;

  typedef struct {
    logic [26:0]  tag;
    logic [255:0] data;
    logic [7:0]   en;
    int           conf;
  } wr_exp_t;

  typedef struct {
    logic [2:0] warp;
    logic [1:0] scb;
    logic [7:0] mask;
    bit         has_wr;
  } fb_exp_t;

  logic         clk = 1'b0;
  logic         resetb = 1'b0;
  logic         st_valid = 1'b0;
  logic         st_ready;
  logic [2:0]   warp_ID = '0;
  logic [1:0]   scb_ID = '0;
  logic [7:0]   thread_mask = '0;
  logic [255:0] st_addr = '0;
  logic [255:0] st_data = '0;
  logic         wr_valid_o;
  logic         wr_ready = 1'b1;
  logic [26:0]  wr_line_addr_o;
  logic [255:0] wr_data_o;
  logic [7:0]   wr_word_en_o;
  logic         fb_valid;
  logic [2:0]   fb_warp;
  logic [1:0]   fb_scb;
  logic [7:0]   fb_mask;
`ifdef MEM_ST_PACK_STATS_EN
  logic [15:0]  stat_lines;
  logic [15:0]  stat_conflicts;
`endif

  mem_store_packer dut (
    .clk                   (clk),
    .resetb                (resetb),
    .st_valid              (st_valid),
    .st_ready              (st_ready),
    .warp_ID               (warp_ID),
    .scb_ID                (scb_ID),
    .thread_mask           (thread_mask),
    .st_addr               (st_addr),
    .st_data               (st_data),
    .wr_valid_o            (wr_valid_o),
    .wr_ready              (wr_ready),
    .wr_line_addr_o        (wr_line_addr_o),
    .wr_data_o             (wr_data_o),
    .wr_word_en_o          (wr_word_en_o),
    .pos_feedback_valid_o  (fb_valid),
    .pos_feedback_warpID_o (fb_warp),
    .pos_feedback_scbID_o  (fb_scb),
    .pos_feedback_mask_o   (fb_mask)
`ifdef MEM_ST_PACK_STATS_EN
    ,
    .stat_lines_o          (stat_lines),
    .stat_conflicts_o      (stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int rdy_mode = 0;
  int exp_lines = 0;
  int exp_conf = 0;

  wr_exp_t     wr_q[$];
  fb_exp_t     fb_q[$];
  logic [31:0] sa [8];
  logic [31:0] sd [8];

  bit           hold_pending = 0;
  logic [26:0]  h_tag;
  logic [255:0] h_data;
  logic [7:0]   h_en;

  task automatic check_eq(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       wr_ready = 1'b1;
      1:       wr_ready = 1'($urandom_range(0, 1));
      default: wr_ready = 1'b0;
    endcase
  end

  // Reference: distinct lines in order of their lowest active lane; each word
  // carries the data of the highest active lane that targets it.
  task automatic model_push(input logic [7:0] m, input logic [2:0] w, input logic [1:0] s);
    logic [26:0] tags[$];
    fb_exp_t     f;
    for (int i = 0; i < 8; i++) begin
      bit seen = 0;
      if (m[i]) begin
        foreach (tags[k]) if (tags[k] == sa[i][31:5]) seen = 1;
        if (!seen) tags.push_back(sa[i][31:5]);
      end
    end
    foreach (tags[k]) begin
      wr_exp_t e;
      e.tag = tags[k]; e.data = '0; e.en = '0; e.conf = 0;
      for (int wd = 0; wd < 8; wd++) begin
        int n = 0;
        for (int i = 0; i < 8; i++) begin
          if (m[i] && sa[i][31:5] == tags[k] && int'(sa[i][4:2]) == wd) begin
            n++;
            e.data[wd*32 +: 32] = sd[i];
          end
        end
        if (n > 0) begin
          e.en[wd] = 1'b1;
          e.conf += n - 1;
        end
      end
      wr_q.push_back(e);
    end
    f.warp = w; f.scb = s; f.mask = m; f.has_wr = (m != 8'h00);
    fb_q.push_back(f);
  endtask

  always @(negedge clk) begin
    if (!resetb) begin
      hold_pending = 0;
    end else begin
      if (hold_pending) begin
        check_eq("hold_valid", 256'(wr_valid_o), 256'(1));
        check_eq("hold_line", 256'(wr_line_addr_o), 256'(h_tag));
        check_eq("hold_data", wr_data_o, h_data);
        check_eq("hold_en", 256'(wr_word_en_o), 256'(h_en));
        check_eq("hold_st_ready", 256'(st_ready), 256'(0));
        hold_pending = 0;
      end
      if (wr_valid_o && wr_ready) begin
        if (wr_q.size() == 0) begin
          fail_now("unexpected_write");
        end else begin
          wr_exp_t e;
          e = wr_q.pop_front();
          check_eq("wr_line", 256'(wr_line_addr_o), 256'(e.tag));
          check_eq("wr_data", wr_data_o, e.data);
          check_eq("wr_en", 256'(wr_word_en_o), 256'(e.en));
          exp_lines++;
          exp_conf += e.conf;
        end
        last_wr_cyc = cyc;
      end else if (wr_valid_o) begin
        h_tag = wr_line_addr_o; h_data = wr_data_o; h_en = wr_word_en_o;
        hold_pending = 1;
      end
      if (fb_valid) begin
        if (fb_q.size() == 0) begin
          fail_now("unexpected_feedback");
        end else begin
          fb_exp_t f;
          f = fb_q.pop_front();
          check_eq("fb_warp", 256'(fb_warp), 256'(f.warp));
          check_eq("fb_scb", 256'(fb_scb), 256'(f.scb));
          check_eq("fb_mask", 256'(fb_mask), 256'(f.mask));
          check_eq("fb_writes_left", 256'(wr_q.size()), 256'(0));
          if (f.has_wr) check_eq("fb_latency", 256'(cyc), 256'(last_wr_cyc + 1));
        end
      end
    end
  end

  task automatic issue(input logic [7:0] m, input logic [2:0] w, input logic [1:0] s);
    int guard = 0;
    @(negedge clk);
    while (!st_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!st_ready) begin
      fail_now("st_ready_timeout");
      return;
    end
    model_push(m, w, s);
    for (int i = 0; i < 8; i++) begin
      st_addr[i*32 +: 32] = sa[i];
      st_data[i*32 +: 32] = sd[i];
    end
    thread_mask = m; warp_ID = w; scb_ID = s; st_valid = 1'b1;
    @(posedge clk);
    #1 st_valid = 1'b0;
    @(negedge clk);
    check_eq("first_wr_latency", 256'(wr_valid_o), 256'(m != 8'h00));
    check_eq("empty_fb_latency", 256'(fb_valid), 256'(m == 8'h00));
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((fb_q.size() != 0 || wr_q.size() != 0 || !st_ready) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) fail_now("drain_timeout");
  endtask

  task automatic gen_random();
    logic [26:0] bases [4];
    for (int b = 0; b < 4; b++) bases[b] = 27'($urandom);
    for (int i = 0; i < 8; i++) begin
      sa[i] = {bases[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      sd[i] = $urandom;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_st_ready", 256'(st_ready), 256'(1));
    check_eq("rst_wr_valid", 256'(wr_valid_o), 256'(0));
    check_eq("rst_wr_line", 256'(wr_line_addr_o), 256'(0));
    check_eq("rst_wr_data", wr_data_o, 256'(0));
    check_eq("rst_wr_en", 256'(wr_word_en_o), 256'(0));
    check_eq("rst_fb", 256'({fb_valid, fb_warp, fb_scb, fb_mask}), 256'(0));
    resetb = 1'b1;

    // Full warp into one line
    for (int i = 0; i < 8; i++) begin sa[i] = 32'h1000 + 32'(4*i); sd[i] = 32'(i); end
    issue(8'hFF, 3'd1, 2'd1);
    wait_idle();

    // Two lines, back to back
    for (int i = 0; i < 8; i++) begin sa[i] = $urandom; sd[i] = $urandom; end
    sa[0] = 32'h200; sa[2] = 32'h208; sa[1] = 32'h400; sa[3] = 32'h40C;
    issue(8'h0F, 3'd2, 2'd3);
    wait_idle();

    // Backpressure on the first write
    rdy_mode = 2;
    sa[0] = 32'h3000; sa[1] = 32'h3024;
    issue(8'h03, 3'd3, 2'd0);
    repeat (4) @(negedge clk);
    rdy_mode = 0;
    wait_idle();

    // Two lanes collide on one word
    sa[1] = 32'h2004; sd[1] = 32'hAAAA_AAAA;
    sa[6] = 32'h2004; sd[6] = 32'hBBBB_BBBB;
    issue(8'h42, 3'd4, 2'd1);
    wait_idle();
`ifdef MEM_ST_PACK_STATS_EN
    check_eq("stat_conflicts", 256'(stat_conflicts), 256'(exp_conf));
    check_eq("stat_lines", 256'(stat_lines), 256'(exp_lines));
`endif

    // Empty mask
    issue(8'h00, 3'd5, 2'd2);
    wait_idle();

    // Randomized traffic with random backpressure
    rdy_mode = 1;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] m;
      gen_random();
      m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      issue(m, 3'($urandom), 2'($urandom));
    end
    rdy_mode = 0;
    wait_idle();
`ifdef MEM_ST_PACK_STATS_EN
    check_eq("stat_lines_rand", 256'(stat_lines), 256'(exp_lines));
    check_eq("stat_conflicts_rand", 256'(stat_conflicts), 256'(exp_conf));
`endif

    // Reset during the second of three writes
    sa[0] = 32'h5000; sa[1] = 32'h6000; sa[2] = 32'h7000;
    issue(8'h07, 3'd6, 2'd3);
    @(posedge clk);
    #1;
    check_eq("rst_mid_pre_valid", 256'(wr_valid_o), 256'(1));
    resetb = 1'b0;
    #1;
    check_eq("rst_mid_wr_valid", 256'(wr_valid_o), 256'(0));
    check_eq("rst_mid_wr_line", 256'(wr_line_addr_o), 256'(0));
    check_eq("rst_mid_wr_data", wr_data_o, 256'(0));
    check_eq("rst_mid_wr_en", 256'(wr_word_en_o), 256'(0));
    check_eq("rst_mid_fb", 256'({fb_valid, fb_warp, fb_scb, fb_mask}), 256'(0));
    wr_q.delete();
    fb_q.delete();
    exp_lines = 0;
    exp_conf = 0;
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("post_rst_no_fb", 256'(fb_valid), 256'(0));
      check_eq("post_rst_no_wr", 256'(wr_valid_o), 256'(0));
    end
    check_eq("post_rst_st_ready", 256'(st_ready), 256'(1));
`ifdef MEM_ST_PACK_STATS_EN
    check_eq("post_rst_stat_lines", 256'(stat_lines), 256'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_store_packer.md
Name: mem_store_packer

Overview:
- Store-side counterpart of the load writeback stage.
- Takes one warp store instruction: 8 lanes, each with a 32-bit address and 32-bit data.
- Groups active lanes by 32-byte cache line and emits one line-write per distinct line, each with a 256-bit data vector and an 8-bit word enable.
- After the last line write is accepted, raises a one-cycle positive scoreboard feedback. Sits between the store address/data stage and the data cache write port.

Parameters:
- NUM_LANES, 8, threads per warp (fixed at 8 for this design).
- WORD_W, 32, bits per lane datum.

Ports:
- clk  in  1  clock
- resetb  in  1  asynchronous active-low reset
- st_valid  in  1  store request valid
- st_ready  out  1  packer can accept a request
- warp_ID  in  3  warp of the store
- scb_ID  in  2  scoreboard entry to release
- thread_mask  in  8  active lanes
- st_addr  in  256  lane i byte address in [32i+31:32i]
- st_data  in  256  lane i store data in [32i+31:32i]
- wr_valid_o  out  1  line write valid
- wr_ready  in  1  cache accepts line write
- wr_line_addr_o  out  27  line address, equal to addr[31:5]
- wr_data_o  out  256  word w in [32w+31:32w]
- wr_word_en_o  out  8  word enables
- pos_feedback_valid_o  out  1  one-cycle completion pulse
- pos_feedback_warpID_o  out  3  captured warp_ID
- pos_feedback_scbID_o  out  2  captured scb_ID
- pos_feedback_mask_o  out  8  captured thread_mask

Behaviour:
- Reset, asynchronous, resetb=0:
  - State goes to IDLE and st_ready=1.
  - wr_valid_o=0, wr_line_addr_o=0, wr_data_o=0, wr_word_en_o=0.
  - pos_feedback_* all 0.
  - Pending mask cleared.
  - Reset mid-operation drops the in-flight store with no feedback.
- Lane decode:
  - Word offset = addr[4:2].
  - Line tag = addr[31:5].
  - addr[1:0] is ignored: word-aligned stores only.
- IDLE:
  - st_ready=1.
  - On st_valid: capture all inputs and set pend=thread_mask.
  - If thread_mask≠0, go to PACK; else go to FB.
- PACK:
  - st_ready=0.
  - Leader = lowest-index lane set in pend.
  - Group = lanes in pend whose tag equals the leader's tag.
  - wr_valid_o=1 and wr_line_addr_o = leader tag.
  - For each group lane, set word_en[off] and place its data in word off.
  - Same-word collision within the group: the highest lane index wins.
  - Outputs are registered and hold stable while wr_valid_o=1 && !wr_ready.
  - On wr_ready: pend &= ~group. If the new pend=0, go to FB; else present the next group in the following cycle.
  - Throughput: one line write per cycle while wr_ready stays high.
- FB:
  - pos_feedback_valid_o=1 for exactly one cycle with the captured IDs and mask.
  - wr_valid_o=0. Next state is IDLE.
  - pos_feedback_valid_o is 0 in all other states.
- Latency: request accepted at cycle T → first wr_valid_o at T+1; feedback one cycle after the final accepted write.
- Empty mask: accept at T → feedback at T+1 with mask 0, no write.
- wr_data_o words whose word_en bit is clear are driven 0.

Optional Feature:
- Macro: MEM_ST_PACK_STATS_EN.
- When defined:
  - Adds outputs stat_lines_o[15:0] (line writes accepted) and stat_conflicts_o[15:0] (same-word lane collisions within a group, counted once per losing lane).
  - Both counters saturate at 16'hFFFF and clear on reset.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mem_pkg:
  - Constants NUM_LANES=8, LINE_BYTES=32, TAG_W=27, OFF_W=3.
  - Typedefs lane_mask_t, line_tag_t, word_off_t.
- Natural sub-module mem_line_group, purely combinational.
  - Inputs: pend, st_addr, st_data.
  - Outputs: leader tag, group mask, packed data, word_en, conflict count.
  - The top holds the FSM and registers.

Test Plan:
- One line: mask=8'hFF, lane i addr=0x1000+4i, data=i → one write: line 0x80, word_en=FF, word i=i; feedback one cycle later with mask FF.
- Scattered lines: mask=8'h0F, lanes 0,2 in line 0x10 and lanes 1,3 in line 0x20, wr_ready=1 → writes to 0x10 (en from lanes 0,2), then 0x20, on consecutive cycles; feedback on the next cycle.
- Backpressure: wr_ready=0 for 5 cycles on the first write → outputs hold stable and st_ready=0; completes normally afterwards.
- Collision: lanes 1 and 6 both at addr 0x2004 with data A and B → word_en=8'h02, word 1 = B; with MEM_ST_PACK_STATS_EN, stat_conflicts_o increments by 1.
- Empty mask: st_valid with mask 0, warp_ID=5, scb_ID=2 → no wr_valid_o; feedback at T+1 with warp 5, scb 2, mask 0.
- Reset mid-operation: assert resetb=0 during the second of three writes → outputs go to 0 immediately, no feedback, st_ready=1 after release.
